// File: rtl/multicycle_datapath.sv
// Multicycle ARM-subset core: datapath and step controller behind one shared memory port.
// Define MCDP_PERF_EN to add the cycle_cnt / retired_cnt performance counters.
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned NREGS     = 16,
    parameter int unsigned STALL_MAX = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [3:0]  alu_flags,
    output logic        instr_done,
    output logic        mem_err
`ifdef MCDP_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_ERR
    } state_t;

    state_t      state;
    logic [31:0] ir, a_reg, b_reg, alu_out, mdr;
    logic [31:0] stall_cnt;
    logic [31:0] rf [0:NREGS-1];

    logic [3:0]  cond, cmd, rn, rd, rm;
    logic [1:0]  op;
    logic        imm_sel, s_bit;

    assign cond    = ir[31:28];
    assign op      = ir[27:26];
    assign imm_sel = ir[25];
    assign cmd     = ir[24:21];
    assign s_bit   = ir[20];   // S for data processing, L for LDR/STR
    assign rn      = ir[19:16];
    assign rd      = ir[15:12];
    assign rm      = ir[3:0];

    // R15 reads as pc+4 here because pc already advanced past the fetched word
    logic [31:0] rn_val, rm_val, rd_val;
    assign rn_val = (rn == 4'd15) ? pc + 32'd4 : rf[rn];
    assign rm_val = (rm == 4'd15) ? pc + 32'd4 : rf[rm];
    assign rd_val = (rd == 4'd15) ? pc + 32'd4 : rf[rd];

    logic [31:0] src_b, alu_res, addr_sum, br_target;
    logic [32:0] add_w, sub_w;
    logic        c_out, v_out, dp_valid, cond_ok;
    logic [3:0]  flags_n;

    always_comb begin
        src_b    = imm_sel ? {24'd0, ir[7:0]} : b_reg;
        add_w    = {1'b0, a_reg} + {1'b0, src_b};
        sub_w    = {1'b0, a_reg} + {1'b0, ~src_b} + 33'd1;
        alu_res  = '0;
        c_out    = 1'b0;
        v_out    = 1'b0;
        dp_valid = 1'b1;
        case (cmd)
            4'b0100: begin
                alu_res = add_w[31:0];
                c_out   = add_w[32];
                v_out   = (a_reg[31] == src_b[31]) && (add_w[31] != a_reg[31]);
            end
            4'b0010: begin
                alu_res = sub_w[31:0];
                c_out   = sub_w[32];
                v_out   = (a_reg[31] != src_b[31]) && (sub_w[31] != a_reg[31]);
            end
            4'b0000: alu_res = a_reg & src_b;
            4'b1100: alu_res = a_reg | src_b;
            default: dp_valid = 1'b0;
        endcase
        flags_n = {alu_res[31], (alu_res == 32'd0), c_out, v_out};
    end

    always_comb begin
        case (cond)
            4'b0000: cond_ok = alu_flags[2];
            4'b0001: cond_ok = ~alu_flags[2];
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign addr_sum  = a_reg + {20'd0, ir[11:0]};
    assign br_target = pc + 32'd4 + {{6{ir[23]}}, ir[23:0], 2'b00};

    logic stalled, timeout;
    assign stalled = mem_req && !mem_ready;
    assign timeout = (STALL_MAX != 0) && stalled && (stall_cnt == STALL_MAX - 1);

    logic        rf_we;
    logic [31:0] wb_data;
    assign rf_we   = (state == S_WB) && (rd != 4'd15);
    assign wb_data = (op == 2'b01) ? mdr : alu_out;

    always_ff @(posedge clk) begin
        if (rf_we)
            rf[rd] <= wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            alu_flags  <= '0;
            instr_done <= 1'b0;
            mem_err    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ir         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            stall_cnt  <= '0;
        end else begin
            instr_done <= 1'b0;
            stall_cnt  <= stalled ? stall_cnt + 32'd1 : '0;
            if (timeout) begin
                state   <= S_ERR;
                mem_err <= 1'b1;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: begin
                        // first fetch after reset has to raise the request itself
                        if (!mem_req) begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {pc[31:2], 2'b00};
                        end else if (mem_ready) begin
                            ir      <= mem_rdata;
                            pc      <= pc + 32'd4;
                            mem_req <= 1'b0;
                            state   <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        a_reg <= rn_val;
                        b_reg <= (op == 2'b01 && !s_bit) ? rd_val : rm_val;
                        state <= S_EXEC;
                    end
                    S_EXEC: begin
                        if (cond_ok && op == 2'b01) begin
                            alu_out   <= addr_sum;
                            mem_req   <= 1'b1;
                            mem_we    <= ~s_bit;
                            mem_addr  <= {addr_sum[31:2], 2'b00};
                            mem_wdata <= b_reg;
                            state     <= s_bit ? S_MEMRD : S_MEMWR;
                        end else if (cond_ok && op == 2'b00 && dp_valid && rd != 4'd15) begin
                            alu_out <= alu_res;
                            if (s_bit)
                                alu_flags <= flags_n;
                            state <= S_WB;
                        end else begin
                            if (cond_ok && op == 2'b00 && dp_valid && s_bit)
                                alu_flags <= flags_n;
                            instr_done <= 1'b1;
                            state      <= S_FETCH;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            if (cond_ok && op == 2'b10) begin
                                pc       <= br_target;
                                mem_addr <= {br_target[31:2], 2'b00};
                            end else begin
                                mem_addr <= {pc[31:2], 2'b00};
                            end
                        end
                    end
                    S_MEMRD: begin
                        if (mem_ready) begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= S_WB;
                        end
                    end
                    S_MEMWR: begin
                        if (mem_ready) begin
                            instr_done <= 1'b1;
                            state      <= S_FETCH;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= {pc[31:2], 2'b00};
                        end
                    end
                    S_WB: begin
                        instr_done <= 1'b1;
                        state      <= S_FETCH;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= {pc[31:2], 2'b00};
                    end
                    S_ERR: begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

`ifdef MCDP_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else if (state != S_ERR) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench for multicycle_datapath: program run, stalls, timeout and async reset abort.
module tb_multicycle_datapath;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] pc;
    logic [3:0]  alu_flags;
    logic        instr_done, mem_err;
`ifdef MCDP_PERF_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    multicycle_datapath #(.RESET_PC(RESET_PC), .NREGS(16), .STALL_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc(pc), .alu_flags(alu_flags), .instr_done(instr_done), .mem_err(mem_err)
`ifdef MCDP_PERF_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [3:0] flags; int unsigned gap; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    ret_t        ret_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem [0:255];
    int unsigned checks = 0, errors = 0;
    int unsigned cyc = 0, last_done = 0, wait_cnt = 0, data_wait = 3, need;
    bit          sb_on = 1'b0, hold_off = 1'b0;
    logic [31:0] held_addr;
    logic        held_we;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dp(input logic [3:0] cond, input logic i, input logic [3:0] cmd,
                                       input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] op2);
        return {cond, 2'b00, i, cmd, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] ls(input logic l, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] imm);
        return {4'b1110, 2'b01, 6'b011000 | {5'd0, l}, rn, rd, imm};
    endfunction

    function automatic logic [31:0] br(input logic [3:0] cond, input logic [23:0] imm);
        return {cond, 4'b1010, imm};
    endfunction

    task automatic exp_ret(input logic [31:0] p, input logic [3:0] f, input int unsigned g);
        ret_t e;
        e.pc = p; e.flags = f; e.gap = g;
        ret_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    // Memory model plus retire/write scoreboard, evaluated mid-cycle
    always @(negedge clk) begin
        ret_t r;
        wr_t  w;
        cyc++;
        if (instr_done && sb_on && ret_q.size() != 0) begin
            r = ret_q.pop_front();
            check("ret_pc", pc, r.pc);
            check("ret_flags", {28'd0, alu_flags}, {28'd0, r.flags});
            if (r.gap != 0)
                check("ret_gap", cyc - last_done, r.gap);
        end
        if (instr_done)
            last_done = cyc;

        if (mem_req) begin
            if (wait_cnt != 0) begin
                check("addr_stable", mem_addr, held_addr);
                check("we_stable", {31'd0, mem_we}, {31'd0, held_we});
            end else begin
                held_addr = mem_addr;
                held_we   = mem_we;
            end
            need = (mem_addr >= 32'h100) ? data_wait : 0;
            if (hold_off || wait_cnt < need) begin
                mem_ready = 1'b0;
                wait_cnt++;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    if (sb_on && wr_q.size() != 0) begin
                        w = wr_q.pop_front();
                        check("wr_addr", mem_addr, w.addr);
                        check("wr_data", mem_wdata, w.data);
                    end
                end
                wait_cnt = 0;
            end
        end else begin
            // ready without a request must be ignored
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            wait_cnt  = 0;
        end
    end

    initial begin
        int unsigned req_cycles;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]  = dp(4'hE, 1'b1, 4'b0000, 1'b0, 4'd0, 4'd0, 12'd0);   // AND R0,R0,#0
        mem[1]  = dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd1, 12'd5);   // ADD R1,R0,#5
        mem[2]  = dp(4'hE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd2, 12'd7);   // ADD R2,R0,#7
        mem[3]  = dp(4'hE, 1'b0, 4'b0100, 1'b0, 4'd1, 4'd3, 12'd2);   // ADD R3,R1,R2
        mem[4]  = ls(1'b0, 4'd0, 4'd3, 12'h100);                      // STR R3,[R0,#0x100]
        mem[5]  = ls(1'b1, 4'd0, 4'd4, 12'h100);                      // LDR R4,[R0,#0x100]
        mem[6]  = ls(1'b0, 4'd0, 4'd4, 12'h104);                      // STR R4,[R0,#0x104]
        mem[7]  = dp(4'hE, 1'b0, 4'b0010, 1'b1, 4'd1, 4'd5, 12'd1);   // SUBS R5,R1,R1
        mem[8]  = br(4'h1, 24'd0);                                    // BNE
        mem[9]  = ls(1'b1, 4'd0, 4'd6, 12'h200);                      // LDR R6,[R0,#0x200]
        mem[10] = dp(4'hE, 1'b1, 4'b0100, 1'b1, 4'd6, 4'd7, 12'd1);   // ADDS R7,R6,#1
        mem[11] = dp(4'hC, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd3, 12'd9);   // ADDGT R3,R0,#9
        mem[12] = ls(1'b0, 4'd0, 4'd3, 12'h108);                      // STR R3
        mem[13] = ls(1'b0, 4'd0, 4'd7, 12'h10C);                      // STR R7
        mem[14] = ls(1'b0, 4'd0, 4'd15, 12'h110);                     // STR R15
        mem[15] = dp(4'hE, 1'b0, 4'b1100, 1'b0, 4'd1, 4'd9, 12'd2);   // ORR R9,R1,R2
        mem[16] = ls(1'b0, 4'd0, 4'd9, 12'h114);                      // STR R9
        mem[17] = dp(4'hE, 1'b0, 4'b0010, 1'b1, 4'd1, 4'd5, 12'd1);   // SUBS R5,R1,R1
        mem[18] = br(4'h0, 24'hFFFFFE);                               // BEQ self
        mem[128] = 32'h7FFF_FFFF;

        exp_ret(32'h04, 4'h0, 0); exp_ret(32'h08, 4'h0, 4); exp_ret(32'h0C, 4'h0, 4);
        exp_ret(32'h10, 4'h0, 4); exp_ret(32'h14, 4'h0, 7); exp_ret(32'h18, 4'h0, 8);
        exp_ret(32'h1C, 4'h0, 7); exp_ret(32'h20, 4'h6, 4); exp_ret(32'h24, 4'h6, 3);
        exp_ret(32'h28, 4'h6, 8); exp_ret(32'h2C, 4'h9, 4); exp_ret(32'h30, 4'h9, 3);
        exp_ret(32'h34, 4'h9, 7); exp_ret(32'h38, 4'h9, 7); exp_ret(32'h3C, 4'h9, 7);
        exp_ret(32'h40, 4'h9, 4); exp_ret(32'h44, 4'h9, 7); exp_ret(32'h48, 4'h6, 4);
        for (int i = 0; i < 3; i++) exp_ret(32'h48, 4'h6, 3);
        exp_wr(32'h100, 32'd12); exp_wr(32'h104, 32'd12); exp_wr(32'h108, 32'd12);
        exp_wr(32'h10C, 32'h8000_0000); exp_wr(32'h110, 32'h40); exp_wr(32'h114, 32'd7);

        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, RESET_PC);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_flags", {28'd0, alu_flags}, 32'd0);
        check("rst_done", {31'd0, instr_done}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        sb_on = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3000 && (ret_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        check("drain_ret", ret_q.size(), 32'd0);
        check("drain_wr", wr_q.size(), 32'd0);
        sb_on = 1'b0;

        // Timeout: fetch never acknowledged
        hold_off = 1'b1;
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        req_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_err) break;
            if (mem_req) req_cycles++;
        end
        check("err_set", {31'd0, mem_err}, 32'd1);
        check("err_cycles", req_cycles, 32'd8);
        check("err_req", {31'd0, mem_req}, 32'd0);
        repeat (5) @(negedge clk);
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        check("err_pc", pc, RESET_PC);
        reset = 1'b0;
        #1;
        check("err_clr", {31'd0, mem_err}, 32'd0);
        check("err_rst_pc", pc, RESET_PC);

        // Reset mid-store: request must drop without a clock edge
        hold_off  = 1'b0;
        data_wait = 6;
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 300 && !(mem_req && mem_we); i++) @(negedge clk);
        check("memwr_seen", {31'd0, mem_req && mem_we}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_req", {31'd0, mem_req}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_pc", pc, RESET_PC);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("refetch_req", {31'd0, mem_req}, 32'd1);
        check("refetch_addr", mem_addr, RESET_PC);
        check("refetch_we", {31'd0, mem_we}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
